// File: rtl/fifo_uart_dumper.sv
// -----------------------------------------------------------------------------
// fifo_uart_dumper
//
// Purpose:
//   Drains the logic-analyzer capture FIFO one 32-bit sample word at a time.
//   Each word is serialised to the host as a 5-byte 8N1 UART frame:
//     SYNC_BYTE, i_data[31:24], i_data[23:16], i_data[15:8], i_data[7:0]
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (2..65535)
//   SYNC_BYTE     first byte of every frame
//
// Ports:
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_enable      level; new frames may start only while high (sampled in IDLE)
//   i_available   FIFO not-empty flag
//   i_data        FIFO read data, valid one cycle after o_rd
//   o_rd          one-cycle FIFO read request
//   o_tx          UART line, idle high
//   o_busy        high from the POP cycle through the last stop bit
//   o_frame_done  one-cycle pulse after the last stop bit of a frame
//   o_frames      count of completed frames (wraps)
// -----------------------------------------------------------------------------
module fifo_uart_dumper #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_available,
  input  logic [31:0] i_data,
  output logic        o_rd,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [15:0] o_frames
);

  // Bit timer width; a 2-cycle bit still needs one counter bit.
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] POP   = 3'd1;
  localparam logic [2:0] LATCH = 3'd2;
  localparam logic [2:0] START = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] STOP  = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  // Byte index 0 is the sync byte; 1..4 are the word bytes, MSB first.
  localparam logic [2:0] LAST_BYTE = 3'd4;

  logic [2:0]       state_q,    state_d;
  logic [CNT_W-1:0] baud_q,     baud_d;
  logic [2:0]       bit_q,      bit_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [7:0]       shift_q,    shift_d;
  logic [31:0]      word_q,     word_d;
  logic [15:0]      frames_q,   frames_d;

  logic bit_end;
  assign bit_end = (baud_q == CNT_MAX);

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    word_d     = word_q;
    frames_d   = frames_q;

    case (state_q)
      IDLE: begin
        if (i_enable && i_available) begin
          state_d = POP;
        end
      end

      POP: begin
        state_d = LATCH;
      end

      LATCH: begin
        // The FIFO word is only looked at here; it is queued behind the sync
        // byte, which goes straight into the bit shifter.
        word_d     = i_data;
        shift_d    = SYNC_BYTE;
        byte_idx_d = 3'd0;
        bit_d      = 3'd0;
        baud_d     = '0;
        state_d    = START;
      end

      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (byte_idx_q < LAST_BYTE) begin
            // Next byte comes from the top of the remaining word.
            byte_idx_d = byte_idx_q + 3'd1;
            shift_d    = word_q[31:24];
            word_d     = {word_q[23:0], 8'h00};
            state_d    = START;
          end else begin
            state_d = DONE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DONE: begin
        frames_d = frames_q + 16'd1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      byte_idx_q <= 3'd0;
      shift_q    <= 8'h00;
      word_q     <= 32'h0;
      frames_q   <= 16'h0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      frames_q   <= frames_d;
    end
  end

  // Outputs decode directly from the state register so that an asserted
  // reset returns the line to idle without waiting for a clock edge.
  assign o_rd         = (state_q == POP);
  assign o_frame_done = (state_q == DONE);
  assign o_busy       = (state_q == POP)   || (state_q == LATCH) ||
                        (state_q == START) || (state_q == DATA)  ||
                        (state_q == STOP);
  assign o_tx         = (state_q == START) ? 1'b0 :
                        (state_q == DATA)  ? shift_q[0] : 1'b1;
  assign o_frames     = frames_q;

endmodule

// File: tb/tb_fifo_uart_dumper.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_dumper
//
// Bench for fifo_uart_dumper at CLKS_PER_BIT=4. A FIFO model answers o_rd
// with the next queued word one cycle later and pushes the five bytes that
// frame must carry onto an expected-byte queue; a UART decoder samples o_tx
// mid-bit and pops/compares each decoded byte against that queue.
// -----------------------------------------------------------------------------
module tb_fifo_uart_dumper;

  localparam int CPB = 4;

  logic        i_clk       = 1'b0;
  logic        i_rst_n     = 1'b1;
  logic        i_enable    = 1'b0;
  logic        i_available = 1'b0;
  logic [31:0] i_data      = 32'h0;
  logic        o_rd;
  logic        o_tx;
  logic        o_busy;
  logic        o_frame_done;
  logic [15:0] o_frames;

  always #5 i_clk = ~i_clk;

  fifo_uart_dumper #(
    .CLKS_PER_BIT (CPB),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_enable     (i_enable),
    .i_available  (i_available),
    .i_data       (i_data),
    .o_rd         (o_rd),
    .o_tx         (o_tx),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_frames     (o_frames)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] fifo_q[$];
  logic [7:0]  exp_bytes[$];
  int          gaps[$];

  int          cyc             = 0;
  int          n_rd            = 0;
  int          n_done          = 0;
  int          rd_cyc          = -1;
  int          frame_start_cyc = -1;
  int          dec_cnt         = -1;
  int          byte_in_frame   = 0;
  int          busy_low_run    = 0;
  bit          done_in_run     = 1'b0;
  logic        prev_tx         = 1'b1;
  logic        rd_prev         = 1'b0;
  logic [9:0]  dec_bits        = 10'h0;
  logic [15:0] exp_frames      = 16'h0;

  // One clock cycle: FIFO model, frame-length/gap bookkeeping, UART decoder.
  task automatic tick();
    logic [31:0] w;
    logic [7:0]  eb;
    @(negedge i_clk);
    cyc++;

    if (o_rd) begin
      n_rd++;
      rd_cyc = cyc;
      if (fifo_q.size() == 0) begin
        total_cnt++;
        $display("FAIL fifo_empty_read: o_rd=1 at cycle %0d with FIFO empty, required no read", cyc);
      end else begin
        w      = fifo_q.pop_front();
        i_data = w;
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(w[31:24]);
        exp_bytes.push_back(w[23:16]);
        exp_bytes.push_back(w[15:8]);
        exp_bytes.push_back(w[7:0]);
      end
    end else if (!rd_prev) begin
      i_data = $urandom();
    end
    rd_prev     = o_rd;
    i_available = (fifo_q.size() != 0);

    if (o_frame_done) begin
      n_done++;
      total_cnt++;
      if (cyc - frame_start_cyc !== 50 * CPB)
        $display("FAIL frame_length: got %0d cycles, required %0d", cyc - frame_start_cyc, 50 * CPB);
      else
        pass_cnt++;
    end

    if (!o_busy) begin
      busy_low_run++;
      if (o_frame_done) done_in_run = 1'b1;
    end else begin
      if (done_in_run) gaps.push_back(busy_low_run);
      busy_low_run = 0;
      done_in_run  = 1'b0;
    end

    if (dec_cnt < 0) begin
      if (prev_tx === 1'b1 && o_tx === 1'b0) begin
        dec_cnt = 0;
        if (byte_in_frame == 0) frame_start_cyc = cyc;
      end
    end else begin
      dec_cnt++;
    end
    if (dec_cnt >= 0 && (dec_cnt % CPB) == CPB / 2) begin
      dec_bits[dec_cnt / CPB] = o_tx;
      if (dec_cnt / CPB == 9) begin
        total_cnt++;
        if (exp_bytes.size() == 0) begin
          $display("FAIL uart_byte: got %02h, required no byte", dec_bits[8:1]);
        end else begin
          eb = exp_bytes.pop_front();
          if (dec_bits[0] !== 1'b0 || dec_bits[9] !== 1'b1 || dec_bits[8:1] !== eb)
            $display("FAIL uart_byte: got start=%b data=%02h stop=%b, required start=0 data=%02h stop=1",
                     dec_bits[0], dec_bits[8:1], dec_bits[9], eb);
          else
            pass_cnt++;
        end
        dec_cnt       = -1;
        byte_in_frame = (byte_in_frame + 1) % 5;
      end
    end
    prev_tx = o_tx;
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    i_available = 1'b1;
  endtask

  task automatic wait_done(input int target, input int limit);
    for (int k = 0; k < limit && n_done < target; k++) tick();
    total_cnt++;
    if (n_done < target)
      $display("FAIL frame_timeout: frame_done count %0d, required %0d", n_done, target);
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    int bad;
    #1 i_rst_n = 1'b0;
    i_enable = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (o_tx !== 1'b1 || o_rd !== 1'b0 || o_busy !== 1'b0 || o_frame_done !== 1'b0) bad++;
    end
    i_rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_tx !== 1'b1 || o_rd !== 1'b0 || o_busy !== 1'b0 || o_frame_done !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL reset_idle: %0d non-idle cycles, required 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (o_frames !== 16'h0) $display("FAIL reset_frames: got %h, required 0000", o_frames);
    else pass_cnt++;
  endtask

  task automatic test_single();
    int r0, d0, push_cyc;
    r0 = n_rd;
    d0 = n_done;
    push_word(32'h12345678);
    push_cyc = cyc;
    wait_done(d0 + 1, 400);
    exp_frames = exp_frames + 16'd1;
    tick();
    total_cnt++;
    if (rd_cyc !== push_cyc + 1) $display("FAIL rd_latency: o_rd at cycle %0d, required %0d", rd_cyc, push_cyc + 1);
    else pass_cnt++;
    total_cnt++;
    if (frame_start_cyc !== rd_cyc + 2) $display("FAIL start_latency: start bit at cycle %0d, required %0d", frame_start_cyc, rd_cyc + 2);
    else pass_cnt++;
    total_cnt++;
    if (n_rd - r0 !== 1 || n_done - d0 !== 1) $display("FAIL single_counts: rd=%0d done=%0d, required 1 and 1", n_rd - r0, n_done - d0);
    else pass_cnt++;
    total_cnt++;
    if (o_frames !== exp_frames) $display("FAIL single_frames: got %h, required %h", o_frames, exp_frames);
    else pass_cnt++;
    total_cnt++;
    if (exp_bytes.size() != 0) $display("FAIL single_bytes_left: %0d undelivered, required 0", exp_bytes.size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int r0, d0;
    r0 = n_rd;
    d0 = n_done;
    gaps.delete();
    busy_low_run = 0;
    done_in_run  = 1'b0;
    push_word(32'h00000001);
    push_word(32'hDEADBEEF);
    push_word(32'hFFFFFFFF);
    wait_done(d0 + 3, 1000);
    exp_frames = exp_frames + 16'd3;
    for (int k = 0; k < 10; k++) tick();
    total_cnt++;
    if (n_rd - r0 !== 3) $display("FAIL b2b_reads: got %0d, required 3", n_rd - r0);
    else pass_cnt++;
    total_cnt++;
    if (o_frames !== exp_frames) $display("FAIL b2b_frames: got %h, required %h", o_frames, exp_frames);
    else pass_cnt++;
    total_cnt++;
    if (exp_bytes.size() != 0) $display("FAIL b2b_bytes_left: %0d undelivered, required 0", exp_bytes.size());
    else pass_cnt++;
    total_cnt++;
    if (gaps.size() != 2 || gaps[0] != 2 || gaps[1] != 2)
      $display("FAIL b2b_gap: %0d gaps, first=%0d, required 2 gaps of 2 cycles",
               gaps.size(), (gaps.size() > 0) ? gaps[0] : -1);
    else pass_cnt++;
  endtask

  task automatic test_enable_gating();
    int r0, d0, bad;
    i_enable = 1'b0;
    r0 = n_rd;
    d0 = n_done;
    push_word(32'hA1B2C3D4);
    push_word(32'h7700C3E1);
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (o_rd !== 1'b0 || o_tx !== 1'b1 || o_busy !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0 || n_rd != r0) $display("FAIL gate_blocked: %0d active cycles, %0d reads, required 0 and 0", bad, n_rd - r0);
    else pass_cnt++;
    i_enable = 1'b1;
    for (int k = 0; k < 10 && n_rd == r0; k++) tick();
    for (int k = 0; k < 40; k++) tick();
    i_enable = 1'b0;
    wait_done(d0 + 1, 400);
    exp_frames = exp_frames + 16'd1;
    for (int k = 0; k < 60; k++) tick();
    total_cnt++;
    if (n_rd - r0 !== 1 || n_done - d0 !== 1) $display("FAIL gate_midframe: rd=%0d done=%0d, required 1 and 1", n_rd - r0, n_done - d0);
    else pass_cnt++;
    total_cnt++;
    if (fifo_q.size() != 1) $display("FAIL gate_fifo_left: %0d words, required 1", fifo_q.size());
    else pass_cnt++;
    total_cnt++;
    if (o_frames !== exp_frames) $display("FAIL gate_frames: got %h, required %h", o_frames, exp_frames);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int fs0, d0;
    fs0 = frame_start_cyc;
    i_enable = 1'b1;
    for (int k = 0; k < 20 && frame_start_cyc == fs0; k++) tick();
    // Second cycle of data bit 0 of byte 2, which is 8'h00 for this word.
    for (int k = 0; k < 200 && cyc < frame_start_cyc + 21 * CPB + 1; k++) tick();
    total_cnt++;
    if (o_tx !== 1'b0 || o_busy !== 1'b1) $display("FAIL midframe_precond: tx=%b busy=%b, required 0 and 1", o_tx, o_busy);
    else pass_cnt++;
    d0 = n_done;
    #2 i_rst_n = 1'b0;
    #1;
    total_cnt++;
    if (o_tx !== 1'b1 || o_busy !== 1'b0) $display("FAIL async_reset: tx=%b busy=%b, required 1 and 0", o_tx, o_busy);
    else pass_cnt++;
    total_cnt++;
    if (o_frames !== 16'h0) $display("FAIL reset_clears_frames: got %h, required 0000", o_frames);
    else pass_cnt++;
    exp_bytes.delete();
    dec_cnt       = -1;
    byte_in_frame = 0;
    prev_tx       = 1'b1;
    exp_frames    = 16'h0;
    for (int k = 0; k < 3; k++) tick();
    i_rst_n = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    total_cnt++;
    if (n_done != d0 || o_frames !== 16'h0) $display("FAIL reset_no_done: done=%0d frames=%h, required 0 and 0000", n_done - d0, o_frames);
    else pass_cnt++;
    push_word(32'hCAFEF00D);
    wait_done(d0 + 1, 400);
    exp_frames = exp_frames + 16'd1;
    tick();
    total_cnt++;
    if (o_frames !== exp_frames) $display("FAIL after_reset_frames: got %h, required %h", o_frames, exp_frames);
    else pass_cnt++;
    total_cnt++;
    if (exp_bytes.size() != 0) $display("FAIL after_reset_bytes_left: %0d undelivered, required 0", exp_bytes.size());
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int d0;
    for (int k = 0; k < 5; k++) tick();
    force dut.frames_q = 16'hFFFF;
    #1;
    release dut.frames_q;
    tick();
    total_cnt++;
    if (o_frames !== 16'hFFFF) $display("FAIL wrap_preload: got %h, required ffff", o_frames);
    else pass_cnt++;
    d0 = n_done;
    push_word(32'h00FF00FF);
    wait_done(d0 + 1, 400);
    tick();
    total_cnt++;
    if (o_frames !== 16'h0000) $display("FAIL wrap_frames: got %h, required 0000", o_frames);
    else pass_cnt++;
    total_cnt++;
    if (exp_bytes.size() != 0) $display("FAIL wrap_bytes_left: %0d undelivered, required 0", exp_bytes.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_enable_gating();
    test_reset_mid_frame();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
